// File: rtl/inc_stream_decoder_pkg.sv
// rtl/inc_stream_decoder_pkg.sv - shared constants and types for inc_stream_decoder
package inc_stream_decoder_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_OFFSET = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    localparam int                    WRAP_CNT_W   = 8;
    localparam logic [WRAP_CNT_W-1:0] WRAP_CNT_MAX = 8'd255;

endpackage

// File: rtl/inc_stream_decoder_skid_buf2.sv
// rtl/inc_stream_decoder_skid_buf2.sv - generic 2-entry in-order valid/ready buffer
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i    upstream handshake
//   out_valid_o/out_ready_i/out_data_o downstream handshake, head entry
module skid_buf2
    import inc_stream_decoder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push, pop;

    // Ready comes only from registered state, so out_ready never reaches in_ready.
    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = head_q;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = in_data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    tail_d  = in_data_i;
                    state_d = FULL;
                end else if (!push && pop) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    // Head leaves while the new beat arrives: it becomes the head directly.
                    head_d = in_data_i;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/inc_stream_decoder.sv
// rtl/inc_stream_decoder.sv - subtracts OFFSET from each beat, buffers 2 deep, counts wrapped decodes
//
// Ports:
//   CLK, ASYNCRESETN              clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     encoded beats from upstream
//   out_valid/out_ready/out_data  decoded beats to downstream
//   wrap_count                    saturating count of accepted beats with in_data < OFFSET
module inc_stream_decoder
    import inc_stream_decoder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int OFFSET = DEF_OFFSET
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [WRAP_CNT_W-1:0] wrap_count
);

    localparam logic [WIDTH-1:0] OFF = WIDTH'(OFFSET);

    logic [WIDTH-1:0]      dec;
    logic                  push;
    logic                  wrapped;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    // WIDTH-bit subtraction; the borrow falls off the top.
    assign dec     = in_data - OFF;
    assign push    = in_valid && in_ready;
    assign wrapped = push && (in_data < OFF);

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (wrapped && (wrap_cnt_q != WRAP_CNT_MAX)) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_count = wrap_cnt_q;

    skid_buf2 #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk_i      (CLK),
        .rst_ni     (ASYNCRESETN),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (dec),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data)
    );

endmodule

// File: tb/tb_inc_stream_decoder.sv
// tb/tb_inc_stream_decoder.sv - self-checking bench for inc_stream_decoder
module tb_inc_stream_decoder;

    localparam int W   = 8;
    localparam int OFS = 1;

    logic         CLK = 1'b0;
    logic         ASYNCRESETN = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [7:0]   wrap_count;

    int tests = 0;
    int fails = 0;

    inc_stream_decoder #(.WIDTH(W), .OFFSET(OFS)) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .wrap_count (wrap_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of decoded values with capacity 2 and a clamped counter.
    int model_q[$];
    int model_wraps = 0;

    always @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            model_q.delete();
            model_wraps = 0;
        end else begin
            bit acc, rem;
            acc = in_valid && (model_q.size() < 2);
            rem = (model_q.size() > 0) && out_ready;
            if (rem) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back((int'(in_data) - OFS + 256) % 256);
                if (int'(in_data) < OFS && model_wraps < 255) model_wraps++;
            end
        end
    end

    // Observed pops, for literal ordering checks.
    int act_q[$];

    always @(negedge CLK) begin
        chk("out_valid", int'(out_valid), int'(model_q.size() != 0));
        chk("in_ready", int'(in_ready), int'(model_q.size() < 2));
        chk("wrap_count", int'(wrap_count), model_wraps);
        if (model_q.size() != 0) chk("out_data", int'(out_data), model_q[0]);
        if (ASYNCRESETN && out_valid && out_ready) act_q.push_back(int'(out_data));
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int exp2[4];
        int exp3[3];
        int base;
        int bad;

        // Reset then idle
        ASYNCRESETN = 1'b0;
        step(); step();
        ASYNCRESETN = 1'b1;
        step(); step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_wrap", int'(wrap_count), 0);

        // Streaming with wraps
        exp2 = '{8'h00, 8'h01, 8'hFE, 8'hFF};
        act_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 8'h01; step();
        in_data = 8'h02; step();
        in_data = 8'hFF; step();
        in_data = 8'h00; step();
        in_valid = 1'b0;
        step(); step();
        chk("stream_count", act_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("stream_val", (i < act_q.size()) ? act_q[i] : -1, exp2[i]);
        chk("stream_wrap", int'(wrap_count), 1);

        // Backpressure
        exp3 = '{8'h0F, 8'h1F, 8'h2F};
        act_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 8'h10; step();
        in_data = 8'h20; step();
        chk("bp_full_in_ready", int'(in_ready), 0);
        in_data = 8'h30; step(); step();
        chk("bp_held_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        step();
        chk("bp_ready_back", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("bp_count", act_q.size(), 3);
        for (int i = 0; i < 3; i++) chk("bp_val", (i < act_q.size()) ? act_q[i] : -1, exp3[i]);

        // Steady ONE with simultaneous push and pop
        act_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h41;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'h42 + i);
            step();
            chk("one_out_valid", int'(out_valid), 1);
            chk("one_in_ready", int'(in_ready), 1);
        end
        in_valid = 1'b0;
        step(); step();
        chk("one_count", act_q.size(), 9);
        for (int i = 0; i < 9; i++) chk("one_val", (i < act_q.size()) ? act_q[i] : -1, 8'h40 + i);

        // Saturation: 300 zero beats
        act_q.delete();
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        step(); step();
        chk("sat_wrap", int'(wrap_count), 255);
        chk("sat_count", act_q.size(), 300);
        bad = 0;
        foreach (act_q[i]) if (act_q[i] != 8'hFF) bad++;
        chk("sat_all_ff", bad, 0);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 8'h50; step();
        in_data = 8'h60; step();
        chk("pre_rst_full", int'(in_ready), 0);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_wrap", int'(wrap_count), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_out_data", int'(out_data), 0);
        out_ready = 1'b1;
        step(); step();
        chk("arst_hold_valid", int'(out_valid), 0);
        #2;
        ASYNCRESETN = 1'b1;
        act_q.delete();
        in_data = 8'h05;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("post_rst_count", act_q.size(), 1);
        chk("post_rst_val", (act_q.size() > 0) ? act_q[0] : -1, 8'h04);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
